i2c_cmd_arbiter: RTL and testbench

//  Shares one I2C controller command/response FIFO pair between NUM_REQ host requesters.

---
 rtl/i2c_cmd_arbiter.sv | 151 +++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C controller command/response FIFO pair among NUM_REQ
// byte-stream requesters; a grant is held from the first header byte until the response completes.
module i2c_cmd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int I2C_FIFO_WIDTH = 8,
  parameter int RSP_TIMEOUT    = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*I2C_FIFO_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                cmd_full,
  output logic                                cmd_wr_en,
  output logic [I2C_FIFO_WIDTH-1:0]           cmd_wr_data,
  input  logic                                rsp_empty,
  input  logic [I2C_FIFO_WIDTH-1:0]           rsp_rd_data,
  output logic                                rsp_rd_en,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [I2C_FIFO_WIDTH-1:0]           rsp_data,
  input  logic [NUM_REQ-1:0]                  rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]          grant_id,
  output logic                                busy,
  output logic                                timeout_err
);
  localparam int W  = I2C_FIFO_WIDTH;
  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [TW-1:0] WD_MAX = TW'((RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, RSP, DONE} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr_ptr, gnt_nxt;
  logic            gnt_found;
  int              idx;
  logic            rw;
  logic [6:0]      dat_cnt, rsp_cnt, len;
  logic            rd_pend, rd_own;
  logic [TW-1:0]   wd_cnt;
  logic            in_pkt, accept, hold_vld, rsp_hs, wd_run, wd_fire;
  logic [W-1:0]    byte_in;

  assign in_pkt   = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign busy     = (state != IDLE);
  assign hold_vld = |rsp_valid;
  assign rsp_hs   = |(rsp_valid & rsp_ready);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rdy
    assign req_ready[g] = in_pkt & ~cmd_full & (grant_id == GW'(g));
  end

  assign cmd_wr_en   = |(req_valid & req_ready);
  assign cmd_wr_data = req_data[int'(grant_id)*W +: W];
  assign accept      = cmd_wr_en;
  assign byte_in     = cmd_wr_data;
  assign len         = (byte_in[6:0] == 7'd0) ? 7'd1 : byte_in[6:0];

  // Circular scan starting at rr_ptr; first requester found wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_nxt   = rr_ptr;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_nxt   = GW'(idx);
      end
    end
  end

  // Outside RSP/DONE every response byte is a stray and is drained; one read in flight at a time.
  always_comb begin
    rsp_rd_en = 1'b0;
    if (reset && !rsp_empty && !rd_pend) begin
      case (state)
        RSP:                    rsp_rd_en = !hold_vld && (rsp_cnt != 7'd0);
        IDLE, HDR0, HDR1, DATA: rsp_rd_en = 1'b1;
        default:                rsp_rd_en = 1'b0;
      endcase
    end
  end

  assign wd_run  = (RSP_TIMEOUT > 0) && (state == RSP) && !hold_vld && !rd_pend &&
                   !rsp_rd_en && (rsp_cnt != 7'd0);
  assign wd_fire = wd_run && (wd_cnt == WD_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (gnt_found) state_nxt = HDR0;
      HDR0: if (accept) state_nxt = HDR1;
      HDR1: if (accept) state_nxt = (byte_in[7] || rw) ? RSP : DATA;
      DATA: if (accept && dat_cnt == 7'd1) state_nxt = DONE;
      RSP: begin
        if (wd_fire)                            state_nxt = DONE;
        else if (rsp_hs && rsp_cnt == 7'd0)     state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      rw          <= 1'b0;
      dat_cnt     <= '0;
      rsp_cnt     <= '0;
      rd_pend     <= 1'b0;
      rd_own      <= 1'b0;
      wd_cnt      <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_pend     <= rsp_rd_en;
      rd_own      <= rsp_rd_en && (state == RSP);
      timeout_err <= wd_fire;

      if (state == IDLE && gnt_found) grant_id <= gnt_nxt;
      if (state == HDR0 && accept) rw <= byte_in[0];
      if (state == HDR1 && accept) begin
        if (byte_in[7])  rsp_cnt <= 7'd1;
        else if (rw)     rsp_cnt <= len;
        else             dat_cnt <= len;
      end
      if (state == DATA && accept) dat_cnt <= dat_cnt - 7'd1;

      // Bytes read while owning the response path land in the holding reg; drained ones vanish.
      if (rd_own) begin
        rsp_data  <= rsp_rd_data;
        rsp_valid <= NUM_REQ'(1) << grant_id;
        rsp_cnt   <= rsp_cnt - 7'd1;
      end else if (rsp_hs) begin
        rsp_valid <= '0;
      end

      if (rsp_rd_en || state != RSP || wd_fire) wd_cnt <= '0;
      else if (wd_run)                          wd_cnt <= wd_cnt + TW'(1);
      if (wd_fire) rsp_cnt <= '0;

      if (state == DONE)
        rr_ptr <= (grant_id == GW'(NUM_REQ-1)) ? '0 : grant_id + GW'(1);
    end
  end
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: per-requester byte queues, a response FIFO model and
// a negedge monitor logging command bytes, response handshakes and timeout pulses.
module tb_i2c_cmd_arbiter;
  localparam int N = 4;

  logic           clk, reset;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*8-1:0] req_data;
  logic           cmd_full, cmd_wr_en, rsp_empty, rsp_rd_en, busy, timeout_err;
  logic [7:0]     cmd_wr_data, rsp_rd_data, rsp_data;
  logic [1:0]     grant_id;

  i2c_cmd_arbiter #(.NUM_REQ(N), .I2C_FIFO_WIDTH(8), .RSP_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cmd_full(cmd_full), .cmd_wr_en(cmd_wr_en), .cmd_wr_data(cmd_wr_data),
    .rsp_empty(rsp_empty), .rsp_rd_data(rsp_rd_data), .rsp_rd_en(rsp_rd_en),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_q [N][$];
  logic [7:0] rsp_q[$];
  logic [7:0] cmd_d[$];
  int         cmd_g[$];
  logic [7:0] rsp_d[$];
  int         rsp_g[$];
  int         cyc, to_cnt, to_cyc, hs_cyc, stab_err, full_err, under_cnt;
  logic       hold_pend;
  logic [N-1:0] prev_v;
  logic [7:0] prev_d;
  int         n_tests, n_fail;

  // Requester driver plus output monitor; everything is sampled 1ns after the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    rsp_empty = (rsp_q.size() == 0);
    for (int i = 0; i < N; i++) begin
      if (tx_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = tx_q[i][0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) void'(tx_q[i].pop_front());
    if (cmd_wr_en) begin
      cmd_d.push_back(cmd_wr_data);
      cmd_g.push_back(int'(grant_id));
      if (cmd_full) full_err = full_err + 1;
    end
    for (int i = 0; i < N; i++)
      if (rsp_valid[i] && rsp_ready[i]) begin
        rsp_d.push_back(rsp_data);
        rsp_g.push_back(i);
        hs_cyc = cyc;
      end
    if (timeout_err) begin
      to_cnt = to_cnt + 1;
      to_cyc = cyc;
    end
    if (hold_pend && (rsp_valid !== prev_v || rsp_data !== prev_d)) stab_err = stab_err + 1;
    hold_pend = (|rsp_valid) && !(|(rsp_valid & rsp_ready));
    prev_v = rsp_valid;
    prev_d = rsp_data;
  end

  // Response FIFO model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (rsp_rd_en) begin
      if (rsp_q.size() > 0) rsp_rd_data <= rsp_q.pop_front();
      else under_cnt = under_cnt + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 300us");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_tx(input int id, input string nm);
    int n = 0;
    while (tx_q[id].size() != 0 && n < 300) begin tick(); n++; end
    chk({nm, "_tx_drained"}, tx_q[id].size(), 0);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    tick();
    while (busy && n < 300) begin tick(); n++; end
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic clear_logs();
    cmd_d.delete(); cmd_g.delete(); rsp_d.delete(); rsp_g.delete();
    to_cnt = 0; stab_err = 0; full_err = 0;
  endtask

  typedef struct {
    int         id;
    int         nb;
    logic [7:0] b [4];
    int         nr;
    logic [7:0] r [3];
    int         rr;
  } vec_t;

  vec_t vecs[5];
  int   exp_g3 [15];
  logic [7:0] exp_d3 [15];

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; under_cnt = 0; hs_cyc = 0; to_cyc = 0;
    hold_pend = 1'b0;
    clear_logs();
    reset = 1'b0; cmd_full = 1'b0; rsp_ready = '1;

    // Single-packet vectors: bytes in double as expected cmd stream; r = bytes fed and expected back.
    vecs[0] = '{id:1, nb:4, b:'{8'hA0, 8'h02, 8'h11, 8'h22}, nr:0, r:'{8'h00, 8'h00, 8'h00}, rr:2};
    vecs[1] = '{id:0, nb:2, b:'{8'hA1, 8'h03, 8'h00, 8'h00}, nr:3, r:'{8'h5A, 8'h5B, 8'h5C}, rr:1};
    vecs[2] = '{id:2, nb:3, b:'{8'h40, 8'h00, 8'h77, 8'h00}, nr:0, r:'{8'h00, 8'h00, 8'h00}, rr:3};
    vecs[3] = '{id:1, nb:2, b:'{8'hA3, 8'h00, 8'h00, 8'h00}, nr:1, r:'{8'h66, 8'h00, 8'h00}, rr:2};
    vecs[4] = '{id:3, nb:2, b:'{8'h91, 8'h80, 8'h00, 8'h00}, nr:1, r:'{8'hC3, 8'h00, 8'h00}, rr:0};
    exp_g3 = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0};
    exp_d3 = '{8'h10, 8'h01, 8'hD0, 8'h20, 8'h01, 8'hD1, 8'h30, 8'h01, 8'hD2,
               8'h40, 8'h01, 8'hD3, 8'h12, 8'h01, 8'hD4};

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cmd_wr_en", cmd_wr_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rd_en", rsp_rd_en, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_timeout_err", timeout_err, 0);
    @(negedge clk) reset = 1'b1;
    repeat (2) tick();

    // T1/T2/T5 and a zero-length read, table-driven
    for (int v = 0; v < 5; v++) begin
      clear_logs();
      for (int j = 0; j < vecs[v].nb; j++) tx_q[vecs[v].id].push_back(vecs[v].b[j]);
      wait_tx(vecs[v].id, $sformatf("v%0d", v));
      for (int j = 0; j < vecs[v].nr; j++) rsp_q.push_back(vecs[v].r[j]);
      wait_idle($sformatf("v%0d", v));
      tick(); tick();
      chk($sformatf("v%0d_cmd_count", v), cmd_d.size(), vecs[v].nb);
      for (int j = 0; j < vecs[v].nb && j < cmd_d.size(); j++) begin
        chk($sformatf("v%0d_cmd%0d", v, j), cmd_d[j], vecs[v].b[j]);
        chk($sformatf("v%0d_cmd%0d_owner", v, j), cmd_g[j], vecs[v].id);
      end
      chk($sformatf("v%0d_rsp_count", v), rsp_d.size(), vecs[v].nr);
      for (int j = 0; j < vecs[v].nr && j < rsp_d.size(); j++) begin
        chk($sformatf("v%0d_rsp%0d", v, j), rsp_d[j], vecs[v].r[j]);
        chk($sformatf("v%0d_rsp%0d_owner", v, j), rsp_g[j], vecs[v].id);
      end
      chk($sformatf("v%0d_rr_ptr", v), dut.rr_ptr, vecs[v].rr);
    end

    // T3 fairness: all four contend, requester 0 has two packets queued
    clear_logs();
    tx_q[0] = '{8'h10, 8'h01, 8'hD0, 8'h12, 8'h01, 8'hD4};
    tx_q[1] = '{8'h20, 8'h01, 8'hD1};
    tx_q[2] = '{8'h30, 8'h01, 8'hD2};
    tx_q[3] = '{8'h40, 8'h01, 8'hD3};
    for (int i = 0; i < N; i++) wait_tx(i, $sformatf("t3_req%0d", i));
    wait_idle("t3");
    chk("t3_cmd_count", cmd_d.size(), 15);
    for (int j = 0; j < 15 && j < cmd_d.size(); j++) begin
      chk($sformatf("t3_cmd%0d", j), cmd_d[j], exp_d3[j]);
      chk($sformatf("t3_cmd%0d_owner", j), cmd_g[j], exp_g3[j]);
    end

    // T4 backpressure on both sides
    clear_logs();
    @(negedge clk) cmd_full = 1'b1;
    tx_q[2] = '{8'hB1, 8'h03};
    repeat (4) tick();
    chk("t4_full_stall", tx_q[2].size(), 2);
    chk("t4_full_owner", grant_id, 2);
    chk("t4_full_no_wr", cmd_d.size(), 0);
    @(negedge clk) cmd_full = 1'b0;
    wait_tx(2, "t4");
    @(negedge clk) rsp_ready[2] = 1'b0;
    rsp_q = '{8'hE1, 8'hE2, 8'hE3};
    repeat (6) tick();
    chk("t4_hold_valid", rsp_valid, 4'b0100);
    chk("t4_hold_data", rsp_data, 8'hE1);
    chk("t4_hold_no_hs", rsp_d.size(), 0);
    @(negedge clk) rsp_ready[2] = 1'b1;
    wait_idle("t4");
    chk("t4_cmd_count", cmd_d.size(), 2);
    chk("t4_rsp_count", rsp_d.size(), 3);
    for (int j = 0; j < 3 && j < rsp_d.size(); j++) begin
      chk($sformatf("t4_rsp%0d", j), rsp_d[j], 8'hE1 + 8'(j));
      chk($sformatf("t4_rsp%0d_owner", j), rsp_g[j], 2);
    end
    chk("t4_data_stable", stab_err, 0);
    chk("t4_no_wr_when_full", full_err, 0);

    // T6 watchdog: read of 2, only one byte ever arrives
    clear_logs();
    tx_q[3] = '{8'hC1, 8'h02};
    wait_tx(3, "t6");
    rsp_q.push_back(8'h99);
    for (int n = 0; n < 60 && to_cnt == 0; n++) tick();
    chk("t6_timeout_seen", to_cnt, 1);
    chk("t6_timeout_delay", to_cyc - hs_cyc, 17);
    chk("t6_rsp_count", rsp_d.size(), 1);
    chk("t6_rsp_data", (rsp_d.size() > 0) ? rsp_d[0] : 8'h00, 8'h99);
    tick(); tick();
    chk("t6_back_idle", busy, 0);
    chk("t6_single_pulse", to_cnt, 1);
    rsp_q.push_back(8'h55);
    repeat (4) tick();
    chk("t6_stray_drained", rsp_q.size(), 0);
    chk("t6_stray_no_hs", rsp_d.size(), 1);
    chk("t6_stray_no_valid", rsp_valid, 0);
    chk("fifo_no_underflow", under_cnt, 0);

    // Reset mid-DATA: 5-byte write with only 3 data bytes supplied
    clear_logs();
    tx_q[1] = '{8'hA0, 8'h05, 8'h11, 8'h22, 8'h33};
    wait_tx(1, "rst_mid");
    tick();
    chk("rst_mid_in_data", busy, 1);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_req_ready", req_ready, 0);
    chk("rst_mid_cmd_wr_en", cmd_wr_en, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_rsp_data", rsp_data, 0);
    chk("rst_mid_grant_id", grant_id, 0);
    chk("rst_mid_rr_ptr", dut.rr_ptr, 0);
    @(negedge clk) reset = 1'b1;
    clear_logs();
    tx_q[0] = '{8'h20, 8'h01, 8'hEE};
    wait_tx(0, "rst_recover");
    wait_idle("rst_recover");
    chk("rst_recover_count", cmd_d.size(), 3);
    chk("rst_recover_hdr", (cmd_d.size() > 0) ? cmd_d[0] : 8'h00, 8'h20);
    chk("rst_recover_data", (cmd_d.size() > 2) ? cmd_d[2] : 8'h00, 8'hEE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
